raw_window3x3: RTL and testbench
================================

# raw_window3x3

Streaming 3x3 neighbourhood generator, directly downstream of the AXIS-to-raw pixel converter in the stereo VO front end. Consumes the gap-tolerant raw pixel stream (data + valid) plus a start-of-frame pulse. Buffers two image lines in on-chip RAM and emits one fully-populated 3x3 window per interior pixel, tagged with the centre coordinates. Feeds the FAST/BRIEF feature stages.

## Interface
Parameters:
- Data_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 640, pixels per line (minimum 3)
- IMG_HEIGHT, 480, lines per frame (minimum 3)
- COL_WIDTH, 10, column counter width; must satisfy 2^COL_WIDTH >= IMG_WIDTH
- ROW_WIDTH, 9, row counter width; must satisfy 2^ROW_WIDTH >= IMG_HEIGHT

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  asynchronous, active-low reset
- raw_data  in  Data_WIDTH  incoming pixel
- raw_valid  in  1  pixel qualifier; no backpressure, the pixel is accepted whenever this is high
- raw_sof  in  1  start of frame; meaningful only while raw_valid=1, marks that pixel as (row 0, col 0)
- win_data  out  9*Data_WIDTH  window; slice [Data_WIDTH*(3*r+c) +: Data_WIDTH] = pixel (centre_row-1+r, centre_col-1+c), r,c in 0..2
- win_valid  out  1  win_data/win_col/win_row valid, one-cycle pulse per window
- win_col  out  COL_WIDTH  centre column
- win_row  out  ROW_WIDTH  centre row
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame

## Operation
- Input counters col/row track the position of the pixel being accepted. On an accepted pixel, col increments. At col=IMG_WIDTH-1, col wraps to 0 and row increments. At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
- raw_sof with raw_valid forces the current pixel to (0,0); the next pixel is (0,1). This applies even mid-frame: counters restart and line-buffer contents are left as-is. Stale data is never emitted, because output requires row>=2 of the new frame.
- raw_sof without raw_valid is ignored.
- Line buffers: lb0 holds line row-1, lb1 holds line row-2, each IMG_WIDTH deep and addressed by col.
  - On each accepted pixel, read lb0[col] and lb1[col].
  - Write lb0[col] <= raw_data and lb1[col] <= old lb0[col], read-before-write in the same cycle.
- Column shift registers: three 3-pixel columns (top=lb1, mid=lb0, bottom=raw_data) shift by one on every accepted pixel only. Gaps in raw_valid freeze all state.
- A window is emitted for an accepted pixel at (row, col) iff row>=2 and col>=2. Its centre is (row-1, col-1).
- Edge pixels (row 0, row IMG_HEIGHT-1, col 0, col IMG_WIDTH-1) are never window centres. Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Windows never span a line wrap: the col>=2 gate discards the two columns refilled after each wrap.
- frame_done asserts with the window whose triggering pixel is (IMG_HEIGHT-1, IMG_WIDTH-1).

## Timing
- Latency: win_valid rises exactly 1 cycle after the clk edge that accepts the triggering pixel. Throughput is one window per clock at a 100% raw_valid duty cycle.
- Line-buffer RAMs use a synchronous read, matching the 1-cycle output register.
- Reset (rst=0, async assert; deassert synchronised to clk by the integrator):
  - col=0, row=0; shift registers cleared
  - win_valid=0, frame_done=0, win_data=0, win_col=0, win_row=0
  - RAM contents undefined (never exposed before being rewritten)
- Reset mid-frame: all output pulses drop immediately. The first post-reset pixel is (0,0) regardless of raw_sof.
- win_data/win_col/win_row hold their last value while win_valid=0.
- Simultaneous raw_sof and counter wrap: raw_sof wins, and the pixel is (0,0).

## Test plan
- IMG_WIDTH=8, IMG_HEIGHT=6, continuous raw_valid, pixel=(row<<4)|col, raw_sof on the first pixel:
  - -> 24 windows in total.
  - First win_valid 1 cycle after pixel 0x22 is accepted: centre (1,1), slices 0/4/8 = 0x00/0x11/0x22.
  - frame_done arrives with centre (4,6), slice 8 = 0x57.
- Same frame with raw_valid toggling 1-0-0-1 pseudo-randomly -> identical window sequence and values; win_valid never asserted in an idle input cycle.
- Two back-to-back frames, the second with values +0x80 -> windows 25..48 contain only second-frame values; none mix the two frames.
- raw_sof reasserted at pixel (3,5) of frame 1 -> no win_valid for the next 2*8+2 accepted pixels; the first new window has centre (1,1) with new-frame data.
- rst pulsed low mid-line (async, between edges) -> win_valid/frame_done low within the same cycle. The restart frame behaves as in scenario 1.
- Frame of 8x6 with an extra 3 pixels and no raw_sof -> the extras are counted as row 0 of the next frame and produce no windows.

Source files
------------

// File: rtl/raw_window3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3-column shift
// register turn a raw pixel stream into one registered window per interior pixel.
module raw_window3x3 #(
    parameter int Data_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_WIDTH  = 10,
    parameter int ROW_WIDTH  = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [Data_WIDTH-1:0]   raw_data,
    input  logic                    raw_valid,
    input  logic                    raw_sof,
    output logic [9*Data_WIDTH-1:0] win_data,
    output logic                    win_valid,
    output logic [COL_WIDTH-1:0]    win_col,
    output logic [ROW_WIDTH-1:0]    win_row,
    output logic                    frame_done
);

    // Handshake: a pixel is taken on every rising edge with raw_valid=1 (no
    // backpressure); win_valid is a one-cycle pulse, win_* hold otherwise.

    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(IMG_HEIGHT - 1);
    localparam int PW = Data_WIDTH;

    logic [COL_WIDTH-1:0] col, cur_col, next_col, rd_addr;
    logic [ROW_WIDTH-1:0] row, cur_row, next_row;
    logic                 emit, last_pixel;

    logic [PW-1:0]   lb0 [IMG_WIDTH];
    logic [PW-1:0]   lb1 [IMG_WIDTH];
    logic [PW-1:0]   lb0_q, lb1_q;
    logic [3*PW-1:0] col_a, col_b, new_col;
    logic [9*PW-1:0] win_next;

    always_comb begin
        cur_col    = raw_sof ? '0 : col;
        cur_row    = raw_sof ? '0 : row;
        emit       = raw_valid && (cur_row >= ROW_WIDTH'(2)) && (cur_col >= COL_WIDTH'(2));
        last_pixel = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        next_col   = cur_col + COL_WIDTH'(1);
        next_row   = cur_row;
        if (cur_col == COL_LAST) begin
            next_col = '0;
            next_row = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_WIDTH'(1);
        end
        // Sync-read RAM: fetch the column the next pixel will need, so the
        // read data is already registered when that pixel arrives.
        rd_addr = raw_valid ? next_col : col;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (raw_valid) begin
            col <= next_col;
            row <= next_row;
        end
    end

    // rd_addr never equals the write address (IMG_WIDTH >= 3), so read and
    // write ports never collide; lb0_q is the pre-write content of lb0[cur_col].
    always_ff @(posedge clk) begin
        lb0_q <= lb0[rd_addr];
        lb1_q <= lb1[rd_addr];
        if (raw_valid) begin
            lb0[cur_col] <= raw_data;
            lb1[cur_col] <= lb0_q;
        end
    end

    // Column packing: [PW*0] top (row-2), [PW*1] middle (row-1), [PW*2] bottom.
    assign new_col = {raw_data, lb0_q, lb1_q};

    always_comb begin
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            win_next[PW*(3*r+0) +: PW] = col_a[PW*r +: PW];
            win_next[PW*(3*r+1) +: PW] = col_b[PW*r +: PW];
            win_next[PW*(3*r+2) +: PW] = new_col[PW*r +: PW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_a <= '0;
            col_b <= '0;
        end else if (raw_valid) begin
            col_a <= col_b;
            col_b <= new_col;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_data   <= '0;
            win_col    <= '0;
            win_row    <= '0;
        end else begin
            win_valid  <= emit;
            frame_done <= emit && last_pixel;
            if (emit) begin
                win_data <= win_next;
                win_col  <= cur_col - COL_WIDTH'(1);
                win_row  <= cur_row - ROW_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_raw_window3x3.sv
// Bench for raw_window3x3 on an 8x6 image: frame-array reference model,
// per-cycle compare against an expected queue, literal pins and a summary.
module tb_raw_window3x3;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 3;
    localparam int RW = 3;
    localparam int EW = 1 + RW + CW + 9*DW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW-1:0]   raw_data;
    logic            raw_valid;
    logic            raw_sof;
    logic [9*DW-1:0] win_data;
    logic            win_valid;
    logic [CW-1:0]   win_col;
    logic [RW-1:0]   win_row;
    logic            frame_done;

    raw_window3x3 #(
        .Data_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
        .COL_WIDTH(CW), .ROW_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst), .raw_data(raw_data), .raw_valid(raw_valid),
        .raw_sof(raw_sof), .win_data(win_data), .win_valid(win_valid),
        .win_col(win_col), .win_row(win_row), .frame_done(frame_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cur_e;
    logic [EW-1:0] last_e;
    int            n_cmp = 0;
    int            n_err = 0;
    int            phase = 0;
    int            win_cnt = 0;
    bit            exp_now = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The image as last written at each position; a window is just the 3x3
    // block ending at the accepted pixel.
    logic [DW-1:0]   img [H][W];
    int              m_row = 0, m_col = 0, p_r, p_c;
    logic [9*DW-1:0] m_d;

    always @(posedge clk) begin
        exp_now = 1'b0;
        if (!rst) begin
            m_row = 0;
            m_col = 0;
        end else if (raw_valid) begin
            p_r = raw_sof ? 0 : m_row;
            p_c = raw_sof ? 0 : m_col;
            img[p_r][p_c] = raw_data;
            if (p_r >= 2 && p_c >= 2) begin
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        m_d[DW*(3*rr+cc) +: DW] = img[p_r-2+rr][p_c-2+cc];
                exp_q.push_back({(p_r == H-1 && p_c == W-1), RW'(p_r-1), CW'(p_c-1), m_d});
                exp_now = 1'b1;
            end
            if (p_c == W-1) begin
                m_col = 0;
                m_row = (p_r == H-1) ? 0 : p_r + 1;
            end else begin
                m_col = p_c + 1;
                m_row = p_r;
            end
        end
    end

    // ---------------- compare ----------------
    always @(negedge clk) begin
        logic all_msb, any_msb;
        cur_e = '0;
        if (exp_now) begin
            if (exp_q.size() > 0) cur_e = exp_q.pop_front();
            else chk("queue_underflow", 128'(exp_q.size()), 128'(1));
        end
        if (!rst) begin
            chk("rst_valid", 128'(win_valid), 128'(0));
            chk("rst_frame_done", 128'(frame_done), 128'(0));
            chk("rst_data", 128'(win_data), 128'(0));
            chk("rst_col_row", 128'({win_row, win_col}), 128'(0));
            last_e = '0;
        end else if (exp_now) begin
            chk("valid", 128'(win_valid), 128'(1));
            chk("data", 128'(win_data), 128'(cur_e[9*DW-1:0]));
            chk("col", 128'(win_col), 128'(cur_e[9*DW +: CW]));
            chk("row", 128'(win_row), 128'(cur_e[9*DW+CW +: RW]));
            chk("frame_done", 128'(frame_done), 128'(cur_e[EW-1]));
            if ((phase == 1 || phase == 6) && win_cnt == 0) begin
                chk("first_slice0", 128'(win_data[0 +: DW]), 128'(8'h00));
                chk("first_slice4", 128'(win_data[4*DW +: DW]), 128'(8'h11));
                chk("first_slice8", 128'(win_data[8*DW +: DW]), 128'(8'h22));
                chk("first_centre", 128'({win_row, win_col}), 128'({3'd1, 3'd1}));
            end
            if ((phase == 1 || phase == 6) && frame_done) begin
                chk("fd_centre", 128'({win_row, win_col}), 128'({3'd4, 3'd6}));
                chk("fd_slice8", 128'(win_data[8*DW +: DW]), 128'(8'h57));
            end
            if (phase == 3) begin
                all_msb = 1'b1;
                any_msb = 1'b0;
                for (int k = 0; k < 9; k++) begin
                    all_msb &= win_data[DW*k + DW-1];
                    any_msb |= win_data[DW*k + DW-1];
                end
                if (win_cnt >= 24) chk("frame2_only", 128'(all_msb), 128'(1));
                else chk("frame1_only", 128'(any_msb), 128'(0));
            end
            if (phase == 4 && win_cnt == 9) begin
                chk("sof_restart_centre", 128'({win_row, win_col}), 128'({3'd1, 3'd1}));
                chk("sof_restart_slice4", 128'(win_data[4*DW +: DW]), 128'(8'h51));
            end
            last_e = cur_e;
            win_cnt++;
        end else begin
            chk("idle_valid", 128'(win_valid), 128'(0));
            chk("idle_frame_done", 128'(frame_done), 128'(0));
            chk("hold_data", 128'(win_data), 128'(last_e[9*DW-1:0]));
            chk("hold_col_row", 128'({win_row, win_col}), 128'(last_e[9*DW +: CW+RW]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_pixel(input logic [DW-1:0] d, input logic sof, input bit gappy);
        if (gappy) begin
            int n = $urandom_range(0, 2);
            repeat (n) begin
                @(negedge clk);
                raw_valid = 1'b0;
                raw_data  = DW'($urandom);
                raw_sof   = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        raw_valid = 1'b1;
        raw_data  = d;
        raw_sof   = sof;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            raw_valid = 1'b0;
            raw_sof   = 1'b0;
        end
    endtask

    task automatic send_pixels(input logic [DW-1:0] off, input bit sof, input bit gappy, input int count);
        for (int i = 0; i < count; i++)
            drive_pixel(DW'(((i / W) << 4) | (i % W)) + off, sof && (i == 0), gappy);
    endtask

    task automatic start_phase(input int p);
        phase   = p;
        win_cnt = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        raw_valid = 1'b0;
        raw_data  = '0;
        raw_sof   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        start_phase(1);
        send_pixels(8'h00, 1'b1, 1'b0, W*H);
        idle(3);
        chk("count_continuous", 128'(win_cnt), 128'(24));

        start_phase(2);
        send_pixels(8'h00, 1'b1, 1'b1, W*H);
        idle(3);
        chk("count_gappy", 128'(win_cnt), 128'(24));

        start_phase(3);
        send_pixels(8'h00, 1'b1, 1'b0, W*H);
        send_pixels(8'h80, 1'b1, 1'b0, W*H);
        idle(3);
        chk("count_two_frames", 128'(win_cnt), 128'(48));

        start_phase(4);
        send_pixels(8'h00, 1'b1, 1'b0, 3*W + 5);
        send_pixels(8'h40, 1'b1, 1'b0, W*H);
        idle(3);
        chk("count_mid_sof", 128'(win_cnt), 128'(33));

        start_phase(5);
        send_pixels(8'h00, 1'b1, 1'b0, 3*W + 5);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 128'(win_valid), 128'(1));
        #1;
        rst       = 1'b0;
        raw_valid = 1'b0;
        #1;
        chk("async_reset_valid", 128'(win_valid), 128'(0));
        chk("async_reset_fd", 128'(frame_done), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        start_phase(6);
        send_pixels(8'h00, 1'b0, 1'b0, W*H);
        idle(3);
        chk("count_after_reset", 128'(win_cnt), 128'(24));

        start_phase(7);
        send_pixels(8'h00, 1'b1, 1'b0, W*H);
        send_pixels(8'h00, 1'b0, 1'b0, 3);
        idle(3);
        chk("count_with_extras", 128'(win_cnt), 128'(24));

        start_phase(8);
        send_pixels(8'h30, 1'b1, 1'b1, W*H);
        idle(3);
        chk("count_after_extras", 128'(win_cnt), 128'(24));
        chk("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
